serial_add_ctrl: RTL and testbench



---
 rtl/serial_add_pkg.sv | 17 +
 rtl/serial_add_dp.sv | 98 +++++++++
 rtl/serial_add_ctrl.sv | 88 ++++++++
 tb/tb_serial_add_ctrl.sv | 196 +++++++++++++++++++
 4 files changed

// File: rtl/serial_add_pkg.sv
// Shared types and constants for the bit-serial add controller.
package serial_add_pkg;

  localparam int DEF_WIDTH = 8;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_e;

  // bit_idx is never narrower than one bit, even at the minimum width.
  function automatic int idx_w(input int w);
    return (w <= 2) ? 1 : $clog2(w);
  endfunction

endpackage

// File: rtl/serial_add_dp.sv
// Datapath for the serial adder: operand shifters, carry flop, sum shifter, bit counter.
// Optional macro SERIAL_ADD_OVF_EN adds the two's-complement overflow flag.
module serial_add_dp
  import serial_add_pkg::*;
#(
  parameter int WIDTH = DEF_WIDTH,
  localparam int IW = idx_w(WIDTH)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             load_i,
  input  logic             step_i,
  input  logic [WIDTH-1:0] op_a_i,
  input  logic [WIDTH-1:0] op_b_i,
  input  logic             cin_i,
  input  logic             s_i,
  input  logic             co_i,
  output logic             a_bit_o,
  output logic             b_bit_o,
  output logic             carry_o,
  output logic             last_o,
`ifdef SERIAL_ADD_OVF_EN
  output logic             ovf_o,
`endif
  output logic [WIDTH-1:0] sum_o,
  output logic             cout_o,
  output logic [IW-1:0]    bit_idx_o
);

  logic [WIDTH-1:0] a_sh_q, a_sh_d;
  logic [WIDTH-1:0] b_sh_q, b_sh_d;
  logic [WIDTH-1:0] sum_q, sum_d;
  logic             carry_q, carry_d;
  logic             cout_q, cout_d;
  logic [IW-1:0]    idx_q, idx_d;

  assign last_o = (idx_q == IW'(WIDTH - 1));

  always_comb begin
    a_sh_d  = a_sh_q;
    b_sh_d  = b_sh_q;
    sum_d   = sum_q;
    carry_d = carry_q;
    cout_d  = cout_q;
    idx_d   = idx_q;
    if (load_i) begin
      a_sh_d  = op_a_i;
      b_sh_d  = op_b_i;
      carry_d = cin_i;
      sum_d   = '0;
      idx_d   = '0;
    end else if (step_i) begin
      a_sh_d  = a_sh_q >> 1;
      b_sh_d  = b_sh_q >> 1;
      carry_d = co_i;
      sum_d   = {s_i, sum_q[WIDTH-1:1]};
      // Counter returns to 0 on the last bit so it rests at 0 outside RUN.
      idx_d   = last_o ? '0 : idx_q + 1'b1;
      if (last_o) cout_d = co_i;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      a_sh_q  <= '0;
      b_sh_q  <= '0;
      sum_q   <= '0;
      carry_q <= 1'b0;
      cout_q  <= 1'b0;
      idx_q   <= '0;
    end else begin
      a_sh_q  <= a_sh_d;
      b_sh_q  <= b_sh_d;
      sum_q   <= sum_d;
      carry_q <= carry_d;
      cout_q  <= cout_d;
      idx_q   <= idx_d;
    end
  end

`ifdef SERIAL_ADD_OVF_EN
  // On the last bit carry_q is the carry into the MSB.
  logic ovf_q;
  always_ff @(posedge clk) begin
    if (rst)                  ovf_q <= 1'b0;
    else if (step_i & last_o) ovf_q <= carry_q ^ co_i;
  end
  assign ovf_o = ovf_q;
`endif

  assign a_bit_o   = a_sh_q[0];
  assign b_bit_o   = b_sh_q[0];
  assign carry_o   = carry_q;
  assign sum_o     = sum_q;
  assign cout_o    = cout_q;
  assign bit_idx_o = idx_q;

endmodule

// File: rtl/serial_add_ctrl.sv
// Bit-serial add controller driving an external full adder, LSB first.
// Optional macro SERIAL_ADD_OVF_EN adds the ovf output.
module serial_add_ctrl
  import serial_add_pkg::*;
#(
  parameter int WIDTH = DEF_WIDTH,
  localparam int IW = idx_w(WIDTH)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start_valid,
  output logic             start_ready,
  input  logic [WIDTH-1:0] op_a,
  input  logic [WIDTH-1:0] op_b,
  input  logic             cin,
  output logic             X,
  output logic             Y,
  output logic             Ci,
  input  logic             S,
  input  logic             Co,
  output logic [WIDTH-1:0] sum,
  output logic             cout,
`ifdef SERIAL_ADD_OVF_EN
  output logic             ovf,
`endif
  output logic             done_valid,
  input  logic             done_ready,
  output logic             busy,
  output logic [IW-1:0]    bit_idx,
  output state_e           dbg_state
);

  state_e state_q, state_d;
  logic   accept, step, last, a_bit, b_bit, carry;

  // Handshakes: a transfer happens on a rising edge where valid and ready are
  // both high. start_ready is high only in IDLE, done_valid only in DONE; a
  // valid holds its payload until that edge and ready does not wait on valid.
  assign start_ready = (state_q == IDLE);
  assign busy        = (state_q == RUN);
  assign done_valid  = (state_q == DONE);
  assign accept      = start_valid & start_ready;
  assign step        = busy;

  assign X = busy & a_bit;
  assign Y = busy & b_bit;
  assign Ci = busy & carry;

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (accept) state_d = RUN;
      RUN:     if (last) state_d = DONE;
      DONE:    if (done_ready) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) state_q <= IDLE;
    else     state_q <= state_d;
  end

  assign dbg_state = state_q;

  serial_add_dp #(.WIDTH(WIDTH)) u_dp (
    .clk       (clk),
    .rst       (rst),
    .load_i    (accept),
    .step_i    (step),
    .op_a_i    (op_a),
    .op_b_i    (op_b),
    .cin_i     (cin),
    .s_i       (S),
    .co_i      (Co),
    .a_bit_o   (a_bit),
    .b_bit_o   (b_bit),
    .carry_o   (carry),
    .last_o    (last),
`ifdef SERIAL_ADD_OVF_EN
    .ovf_o     (ovf),
`endif
    .sum_o     (sum),
    .cout_o    (cout),
    .bit_idx_o (bit_idx)
  );

endmodule

// File: tb/tb_serial_add_ctrl.sv
// Directed bench for serial_add_ctrl with a behavioural full adder closing the loop.
module tb_serial_add_ctrl;
  import serial_add_pkg::*;

  localparam int W  = 8;
  localparam int IW = idx_w(W);

  logic          clk = 1'b0;
  logic          rst;
  logic          start_valid, start_ready;
  logic [W-1:0]  op_a, op_b;
  logic          cin;
  logic          X, Y, Ci, S, Co;
  logic [W-1:0]  sum;
  logic          cout;
`ifdef SERIAL_ADD_OVF_EN
  logic          ovf;
`endif
  logic          done_valid, done_ready, busy;
  logic [IW-1:0] bit_idx;
  state_e        dbg_state;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  // External full adder.
  assign S  = X ^ Y ^ Ci;
  assign Co = (X & Y) | (X & Ci) | (Y & Ci);

  serial_add_ctrl #(.WIDTH(W)) dut (
    .clk         (clk),
    .rst         (rst),
    .start_valid (start_valid),
    .start_ready (start_ready),
    .op_a        (op_a),
    .op_b        (op_b),
    .cin         (cin),
    .X           (X),
    .Y           (Y),
    .Ci          (Ci),
    .S           (S),
    .Co          (Co),
    .sum         (sum),
    .cout        (cout),
`ifdef SERIAL_ADD_OVF_EN
    .ovf         (ovf),
`endif
    .done_valid  (done_valid),
    .done_ready  (done_ready),
    .busy        (busy),
    .bit_idx     (bit_idx),
    .dbg_state   (dbg_state)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic chk_reset_vals(input string tag);
    chk({tag, "_sum"},   32'(sum), 32'h0);
    chk({tag, "_cout"},  32'(cout), 32'h0);
    chk({tag, "_dv"},    32'(done_valid), 32'h0);
    chk({tag, "_busy"},  32'(busy), 32'h0);
    chk({tag, "_idx"},   32'(bit_idx), 32'h0);
    chk({tag, "_xyc"},   {29'h0, X, Y, Ci}, 32'h0);
    chk({tag, "_sr"},    32'(start_ready), 32'h1);
    chk({tag, "_state"}, 32'(dbg_state), 32'(IDLE));
`ifdef SERIAL_ADD_OVF_EN
    chk({tag, "_ovf"},   32'(ovf), 32'h0);
`endif
  endtask

  // Accept operands, check every RUN cycle, end in DONE with the result checked.
  task automatic run_add(input string tag, input logic [W-1:0] a, input logic [W-1:0] b,
                         input logic c, input logic [W-1:0] es, input logic ec);
    logic mc;
    op_a = a; op_b = b; cin = c; start_valid = 1'b1;
    chk({tag, "_sr_idle"}, 32'(start_ready), 32'h1);
    tick();
    start_valid = 1'b0;
    op_a = ~a; op_b = ~b; cin = ~c;
    mc = c;
    for (int i = 0; i < W; i++) begin
      chk({tag, "_busy"}, 32'(busy), 32'h1);
      chk({tag, "_sr_run"}, 32'(start_ready), 32'h0);
      chk({tag, "_dv_run"}, 32'(done_valid), 32'h0);
      chk({tag, "_idx"}, 32'(bit_idx), 32'(i));
      chk({tag, "_xyc"}, {29'h0, X, Y, Ci}, {29'h0, a[i], b[i], mc});
      mc = (a[i] & b[i]) | (a[i] & mc) | (b[i] & mc);
      tick();
    end
    chk({tag, "_dv"}, 32'(done_valid), 32'h1);
    chk({tag, "_sum"}, 32'(sum), 32'(es));
    chk({tag, "_cout"}, 32'(cout), 32'(ec));
    chk({tag, "_xyc_done"}, {29'h0, X, Y, Ci}, 32'h0);
    chk({tag, "_busy_done"}, 32'(busy), 32'h0);
  endtask

  task automatic release_done(input string tag);
    done_ready = 1'b1;
    tick();
    done_ready = 1'b0;
    chk({tag, "_dv_rel"}, 32'(done_valid), 32'h0);
    chk({tag, "_state_rel"}, 32'(dbg_state), 32'(IDLE));
    chk({tag, "_sr_rel"}, 32'(start_ready), 32'h1);
  endtask

  initial begin
    rst = 1'b1; start_valid = 1'b0; done_ready = 1'b0;
    op_a = '0; op_b = '0; cin = 1'b0;
    tick();
    tick();
    chk_reset_vals("reset");
    rst = 1'b0;
    tick();
    chk_reset_vals("post_reset");

    run_add("add35_4a", 8'h35, 8'h4A, 1'b0, 8'h7F, 1'b0);
    release_done("add35_4a");

    run_add("addff_01", 8'hFF, 8'h01, 1'b0, 8'h00, 1'b1);
    release_done("addff_01");

    run_add("add00_cin", 8'h00, 8'h00, 1'b1, 8'h01, 1'b0);
    release_done("add00_cin");

    // Backpressure: result held, new starts ignored while in DONE.
    run_add("bp", 8'hA5, 8'h3C, 1'b1, 8'hE2, 1'b0);
    for (int k = 0; k < 5; k++) begin
      start_valid = k[0];
      op_a = 8'h11; op_b = 8'h22; cin = 1'b0;
      tick();
      chk("bp_dv", 32'(done_valid), 32'h1);
      chk("bp_sum", 32'(sum), 32'hE2);
      chk("bp_cout", 32'(cout), 32'h0);
      chk("bp_sr", 32'(start_ready), 32'h0);
      chk("bp_xyc", {29'h0, X, Y, Ci}, 32'h0);
    end
    // Both done_ready and start_valid high: only the result handshake completes.
    start_valid = 1'b1;
    done_ready = 1'b1;
    tick();
    chk("bp_rel_state", 32'(dbg_state), 32'(IDLE));
    chk("bp_rel_dv", 32'(done_valid), 32'h0);
    chk("bp_rel_busy", 32'(busy), 32'h0);
    start_valid = 1'b0;
    done_ready = 1'b0;
    tick();
    chk("bp_idle_hold", 32'(dbg_state), 32'(IDLE));

    // Reset in the middle of RUN.
    op_a = 8'h55; op_b = 8'h0F; cin = 1'b0; start_valid = 1'b1;
    tick();
    start_valid = 1'b0;
    tick(); tick(); tick();
    chk("abort_idx", 32'(bit_idx), 32'h3);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    chk_reset_vals("abort");
    for (int k = 0; k < 10; k++) begin
      tick();
      chk("abort_no_dv", 32'(done_valid), 32'h0);
    end

    run_add("add10_20", 8'h10, 8'h20, 1'b0, 8'h30, 1'b0);
    release_done("add10_20");

`ifdef SERIAL_ADD_OVF_EN
    run_add("ovf7f_01", 8'h7F, 8'h01, 1'b0, 8'h80, 1'b0);
    chk("ovf7f_01_ovf", 32'(ovf), 32'h1);
    release_done("ovf7f_01");
    run_add("ovf80_80", 8'h80, 8'h80, 1'b0, 8'h00, 1'b1);
    chk("ovf80_80_ovf", 32'(ovf), 32'h1);
    release_done("ovf80_80");
    run_add("ovf40_20", 8'h40, 8'h20, 1'b0, 8'h60, 1'b0);
    chk("ovf40_20_ovf", 32'(ovf), 32'h0);
    release_done("ovf40_20");
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
